// File: rtl/mover_pkg.sv
// Shared types for sprite movers: motion directions and WASD keycodes.
package mover_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_LEFT  = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_UP    = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_UP    = 8'h1A;

    // Any keycode outside the four movement keys means "no key".
    function automatic dir_t key_to_dir(input logic [7:0] key);
        case (key)
            KEY_LEFT:  return DIR_LEFT;
            KEY_RIGHT: return DIR_RIGHT;
            KEY_UP:    return DIR_UP;
            KEY_DOWN:  return DIR_DOWN;
            default:   return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mover_step.sv
// Candidate-position generator: one STEP along dir, border check and
// optional horizontal tunnel wrap. Purely combinational.
module mover_step
    import mover_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int SIZE    = 13,
    parameter int X_MIN   = 7,
    parameter int X_MAX   = 396,
    parameter int Y_MIN   = 7,
    parameter int Y_MAX   = 440,
    parameter int STEP    = 1,
    parameter int WRAP_X  = 0
) (
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  dir_t               dir,
    output logic [COORD_W-1:0] cand_x,
    output logic [COORD_W-1:0] cand_y,
    output logic               legal
);

    // Two extra bits: one for sign, one for headroom above the maze.
    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] S_STEP = SW'(STEP);
    localparam logic signed [SW-1:0] S_SIZE = SW'(SIZE);
    localparam logic signed [SW-1:0] S_XMIN = SW'(X_MIN);
    localparam logic signed [SW-1:0] S_XMAX = SW'(X_MAX);
    localparam logic signed [SW-1:0] S_YMIN = SW'(Y_MIN);
    localparam logic signed [SW-1:0] S_YMAX = SW'(Y_MAX);

    logic signed [SW-1:0] px, py, cx, cy;

    // Step along the axis of dir, then bound-check (or wrap) that axis.
    always_comb begin
        px    = $signed({2'b00, pos_x});
        py    = $signed({2'b00, pos_y});
        cx    = px;
        cy    = py;
        legal = 1'b0;
        case (dir)
            DIR_LEFT, DIR_RIGHT: begin
                cx = (dir == DIR_LEFT) ? px - S_STEP : px + S_STEP;
                if (cx - S_SIZE < S_XMIN) begin
                    if (WRAP_X != 0) begin
                        cx    = S_XMAX - S_SIZE;
                        legal = 1'b1;
                    end
                end else if (cx + S_SIZE > S_XMAX) begin
                    if (WRAP_X != 0) begin
                        cx    = S_XMIN + S_SIZE;
                        legal = 1'b1;
                    end
                end else begin
                    legal = 1'b1;
                end
            end
            DIR_UP, DIR_DOWN: begin
                cy    = (dir == DIR_UP) ? py - S_STEP : py + S_STEP;
                legal = (cy - S_SIZE >= S_YMIN) && (cy + S_SIZE <= S_YMAX);
            end
            default: legal = 1'b0;
        endcase
    end

    assign cand_x = cx[COORD_W-1:0];
    assign cand_y = cy[COORD_W-1:0];

endmodule

// File: rtl/sprite_mover.sv
// Keyboard/AI-driven sprite mover: queued turns, frame-rate divider and
// a wall-probe req/ack handshake before every committed move.
module sprite_mover
    import mover_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int SIZE       = 13,
    parameter int X_MIN      = 7,
    parameter int X_MAX      = 396,
    parameter int Y_MIN      = 7,
    parameter int Y_MAX      = 440,
    parameter int X_START    = 202,
    parameter int Y_START    = 253,
    parameter int STEP       = 1,
    parameter int FRAME_DIV  = 1,
    parameter int CONTINUOUS = 1,
    parameter int WRAP_X     = 0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic [7:0]         keycode,
    output logic               wall_req,
    output logic [COORD_W-1:0] wall_x,
    output logic [COORD_W-1:0] wall_y,
    input  logic               wall_ack,
    input  logic               wall_hit,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [COORD_W-1:0] size,
    output dir_t               dir,
    output dir_t               last_dir,
    output logic               moving,
    output logic               overrun
);

    typedef enum logic [1:0] {IDLE, TRY_TURN, TRY_FWD} state_t;

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [COORD_W-1:0] wall_x_q, wall_x_d, wall_y_q, wall_y_d;
    dir_t               dir_q, dir_d, last_dir_q, last_dir_d;
    dir_t               pend_q, pend_d, try_dir_q, try_dir_d;
    logic               req_q, req_d, moving_q, moving_d, overrun_q, overrun_d;
    logic [DIV_W-1:0]   div_q, div_d;

    dir_t               key_dir, step_dir;
    logic               key_valid, slot, want_turn;
    logic [COORD_W-1:0] cand_x, cand_y;
    logic               cand_legal;

    assign key_dir   = key_to_dir(keycode);
    assign key_valid = (key_dir != DIR_NONE);
    assign want_turn = (pend_q != DIR_NONE) && (pend_q != dir_q);
    assign slot      = frame_tick && (state_q == IDLE) && (div_q == DIV_LAST);

    // The single step unit tests the turn or the forward direction.
    always_comb begin
        step_dir = dir_q;
        if (state_q == IDLE && want_turn) step_dir = pend_q;
    end

    mover_step #(
        .COORD_W(COORD_W), .SIZE(SIZE),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .STEP(STEP), .WRAP_X(WRAP_X)
    ) u_step (
        .pos_x (pos_x_q),
        .pos_y (pos_y_q),
        .dir   (step_dir),
        .cand_x(cand_x),
        .cand_y(cand_y),
        .legal (cand_legal)
    );

    // Next-state: divider, move FSM and probe handshake, then key capture.
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        wall_x_d   = wall_x_q;
        wall_y_d   = wall_y_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        pend_d     = pend_q;
        try_dir_d  = try_dir_q;
        req_d      = req_q;
        moving_d   = moving_q;
        overrun_d  = 1'b0;
        div_d      = div_q;

        // Ticks while a move is in flight are dropped, not queued.
        if (frame_tick) begin
            if (state_q != IDLE) overrun_d = 1'b1;
            else                 div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (slot) begin
                    if (CONTINUOUS == 0 && !key_valid) begin
                        pend_d   = DIR_NONE;
                        dir_d    = DIR_NONE;
                        moving_d = 1'b0;
                    end else if (want_turn) begin
                        try_dir_d = pend_q;
                        if (cand_legal) begin
                            req_d    = 1'b1;
                            wall_x_d = cand_x;
                            wall_y_d = cand_y;
                            state_d  = TRY_TURN;
                        end else if (dir_q != DIR_NONE) begin
                            state_d = TRY_FWD;
                        end else begin
                            moving_d = 1'b0;
                        end
                    end else if (dir_q != DIR_NONE) begin
                        try_dir_d = dir_q;
                        if (cand_legal) begin
                            req_d    = 1'b1;
                            wall_x_d = cand_x;
                            wall_y_d = cand_y;
                            state_d  = TRY_FWD;
                        end else begin
                            moving_d = 1'b0;
                        end
                    end else begin
                        moving_d = 1'b0;
                    end
                end
            end
            TRY_TURN: begin
                if (req_q && wall_ack) begin
                    req_d = 1'b0;
                    if (!wall_hit) begin
                        pos_x_d    = wall_x_q;
                        pos_y_d    = wall_y_q;
                        dir_d      = try_dir_q;
                        last_dir_d = try_dir_q;
                        pend_d     = DIR_NONE;
                        moving_d   = 1'b1;
                        state_d    = IDLE;
                    end else if (dir_q != DIR_NONE) begin
                        state_d = TRY_FWD;
                    end else begin
                        moving_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            TRY_FWD: begin
                if (!req_q) begin
                    // Entered after a failed turn: probe forward now.
                    try_dir_d = dir_q;
                    if (cand_legal) begin
                        req_d    = 1'b1;
                        wall_x_d = cand_x;
                        wall_y_d = cand_y;
                    end else begin
                        moving_d = 1'b0;
                        state_d  = IDLE;
                    end
                end else if (wall_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!wall_hit) begin
                        pos_x_d    = wall_x_q;
                        pos_y_d    = wall_y_q;
                        last_dir_d = dir_q;
                        moving_d   = 1'b1;
                    end else begin
                        moving_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Newest key wins; it never touches the probe already in flight.
        if (key_valid) pend_d = key_dir;
    end

    // State registers; reset abandons any probe in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            pos_x_q    <= COORD_W'(X_START);
            pos_y_q    <= COORD_W'(Y_START);
            wall_x_q   <= '0;
            wall_y_q   <= '0;
            dir_q      <= DIR_NONE;
            last_dir_q <= DIR_LEFT;
            pend_q     <= DIR_NONE;
            try_dir_q  <= DIR_NONE;
            req_q      <= 1'b0;
            moving_q   <= 1'b0;
            overrun_q  <= 1'b0;
            div_q      <= '0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            wall_x_q   <= wall_x_d;
            wall_y_q   <= wall_y_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            pend_q     <= pend_d;
            try_dir_q  <= try_dir_d;
            req_q      <= req_d;
            moving_q   <= moving_d;
            overrun_q  <= overrun_d;
            div_q      <= div_d;
        end
    end

    assign wall_req = req_q;
    assign wall_x   = wall_x_q;
    assign wall_y   = wall_y_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign size     = COORD_W'(SIZE);
    assign dir      = dir_q;
    assign last_dir = last_dir_q;
    assign moving   = moving_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: four instances with different
// parameters, a combinational wall ROM model per instance.
module tb_sprite_mover;
    import mover_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] key    [4] = '{default: 8'h00};
    logic       ack_en [4] = '{default: 1'b1};
    logic       hit_h  [4] = '{default: 1'b0};
    logic       hit_v  [4] = '{default: 1'b0};

    logic       req [4], ack [4], hit [4], mv [4], ov [4];
    logic [9:0] wx [4], wy [4], px [4], py [4], sz [4];
    dir_t       dr [4], ld [4];

    int n_chk = 0;
    int n_fail = 0;
    int probes [4] = '{default: 0};
    logic req_prev [4] = '{default: 1'b0};

    always #5 Clk = ~Clk;

    // ROM model: answers in the request cycle; vertical probes use hit_v.
    for (genvar g = 0; g < 4; g++) begin : g_rom
        assign ack[g] = req[g] & ack_en[g];
        assign hit[g] = (wy[g] != py[g]) ? hit_v[g] : hit_h[g];
    end

    // Count probes as rising edges of wall_req.
    always @(posedge Clk) begin
        for (int k = 0; k < 4; k++) begin
            if (req[k] === 1'b1 && req_prev[k] !== 1'b1) probes[k] <= probes[k] + 1;
            req_prev[k] <= req[k];
        end
    end

    sprite_mover u_dut0 (
        .Clk(Clk), .Reset(Reset), .frame_tick(tick), .keycode(key[0]),
        .wall_req(req[0]), .wall_x(wx[0]), .wall_y(wy[0]), .wall_ack(ack[0]), .wall_hit(hit[0]),
        .pos_x(px[0]), .pos_y(py[0]), .size(sz[0]), .dir(dr[0]), .last_dir(ld[0]),
        .moving(mv[0]), .overrun(ov[0]));

    sprite_mover #(.FRAME_DIV(4)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .frame_tick(tick), .keycode(key[1]),
        .wall_req(req[1]), .wall_x(wx[1]), .wall_y(wy[1]), .wall_ack(ack[1]), .wall_hit(hit[1]),
        .pos_x(px[1]), .pos_y(py[1]), .size(sz[1]), .dir(dr[1]), .last_dir(ld[1]),
        .moving(mv[1]), .overrun(ov[1]));

    sprite_mover #(.WRAP_X(1), .X_START(20)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .frame_tick(tick), .keycode(key[2]),
        .wall_req(req[2]), .wall_x(wx[2]), .wall_y(wy[2]), .wall_ack(ack[2]), .wall_hit(hit[2]),
        .pos_x(px[2]), .pos_y(py[2]), .size(sz[2]), .dir(dr[2]), .last_dir(ld[2]),
        .moving(mv[2]), .overrun(ov[2]));

    sprite_mover #(.X_START(381)) u_dut3 (
        .Clk(Clk), .Reset(Reset), .frame_tick(tick), .keycode(key[3]),
        .wall_req(req[3]), .wall_x(wx[3]), .wall_y(wy[3]), .wall_ack(ack[3]), .wall_hit(hit[3]),
        .pos_x(px[3]), .pos_y(py[3]), .size(sz[3]), .dir(dr[3]), .last_dir(ld[3]),
        .moving(mv[3]), .overrun(ov[3]));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    // One-cycle tick, then enough idle cycles for any probe sequence.
    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge Clk) tick = 1'b1;
            @(negedge Clk) tick = 1'b0;
            repeat (6) @(negedge Clk);
        end
    endtask

    typedef struct {
        logic [7:0] key;
        int         nt;
        logic       hh, hv;
        int         ex, ey;
        dir_t       ed, eld;
        logic       em;
        int         ep;
    } vec_t;

    vec_t tv [9];

    initial begin
        int p;
        tv[0] = '{8'h00, 2, 1'b0, 1'b0, 202, 253, DIR_NONE,  DIR_LEFT,  1'b0, 0};
        tv[1] = '{8'h07, 3, 1'b0, 1'b0, 205, 253, DIR_RIGHT, DIR_RIGHT, 1'b1, 3};
        tv[2] = '{8'h00, 2, 1'b0, 1'b0, 207, 253, DIR_RIGHT, DIR_RIGHT, 1'b1, 2};
        tv[3] = '{8'h00, 1, 1'b1, 1'b0, 207, 253, DIR_RIGHT, DIR_RIGHT, 1'b0, 1};
        tv[4] = '{8'h1A, 1, 1'b0, 1'b1, 208, 253, DIR_RIGHT, DIR_RIGHT, 1'b1, 2};
        tv[5] = '{8'h00, 1, 1'b0, 1'b0, 208, 252, DIR_UP,    DIR_UP,    1'b1, 1};
        tv[6] = '{8'h04, 2, 1'b0, 1'b0, 206, 252, DIR_LEFT,  DIR_LEFT,  1'b1, 2};
        tv[7] = '{8'h16, 1, 1'b1, 1'b1, 206, 252, DIR_LEFT,  DIR_LEFT,  1'b0, 2};
        tv[8] = '{8'h16, 1, 1'b0, 1'b0, 206, 253, DIR_DOWN,  DIR_DOWN,  1'b1, 1};

        do_reset();
        chk("rst_px", int'(px[0]), 202);
        chk("rst_py", int'(py[0]), 253);
        chk("rst_dir", int'(dr[0]), int'(DIR_NONE));
        chk("rst_last", int'(ld[0]), int'(DIR_LEFT));
        chk("rst_req", int'(req[0]), 0);
        chk("rst_mv", int'(mv[0]), 0);
        chk("rst_ov", int'(ov[0]), 0);
        chk("size", int'(sz[0]), 13);

        for (int i = 0; i < 9; i++) begin
            key[0]   = tv[i].key;
            hit_h[0] = tv[i].hh;
            hit_v[0] = tv[i].hv;
            p = probes[0];
            ticks(tv[i].nt);
            chk($sformatf("v%0d_px", i), int'(px[0]), tv[i].ex);
            chk($sformatf("v%0d_py", i), int'(py[0]), tv[i].ey);
            chk($sformatf("v%0d_dir", i), int'(dr[0]), int'(tv[i].ed));
            chk($sformatf("v%0d_last", i), int'(ld[0]), int'(tv[i].eld));
            chk($sformatf("v%0d_mv", i), int'(mv[0]), int'(tv[i].em));
            chk($sformatf("v%0d_probes", i), probes[0] - p, tv[i].ep);
        end

        // Forward move at minimum latency: req next cycle, pos one later.
        @(negedge Clk) tick = 1'b1;
        @(negedge Clk) tick = 1'b0;
        chk("lat2_req", int'(req[0]), 1);
        chk("lat2_wy", int'(wy[0]), 254);
        @(negedge Clk);
        chk("lat2_py", int'(py[0]), 254);
        chk("lat2_req_drop", int'(req[0]), 0);
        repeat (4) @(negedge Clk);

        // Blocked turn then forward move: four-cycle path.
        key[0] = 8'h07; hit_h[0] = 1'b1; hit_v[0] = 1'b0;
        @(negedge Clk) tick = 1'b1;
        @(negedge Clk) tick = 1'b0;
        chk("lat4_turn_req", int'(req[0]), 1);
        chk("lat4_turn_wx", int'(wx[0]), 207);
        @(negedge Clk);
        chk("lat4_gap_req", int'(req[0]), 0);
        @(negedge Clk);
        chk("lat4_fwd_req", int'(req[0]), 1);
        chk("lat4_fwd_wy", int'(wy[0]), 255);
        chk("lat4_py_hold", int'(py[0]), 254);
        @(negedge Clk);
        chk("lat4_py", int'(py[0]), 255);
        chk("lat4_dir", int'(dr[0]), int'(DIR_DOWN));
        repeat (4) @(negedge Clk);

        // Stalled probe: overrun on extra tick, key change ignored, async reset.
        ack_en[0] = 1'b0; key[0] = 8'h00; hit_h[0] = 1'b0;
        @(negedge Clk) tick = 1'b1;
        @(negedge Clk) tick = 1'b0;
        chk("stall_req", int'(req[0]), 1);
        chk("stall_wx", int'(wx[0]), 207);
        key[0] = 8'h04;
        @(negedge Clk) tick = 1'b1;
        @(negedge Clk) tick = 1'b0;
        chk("ovr_pulse", int'(ov[0]), 1);
        chk("ovr_wx_hold", int'(wx[0]), 207);
        @(negedge Clk);
        chk("ovr_clear", int'(ov[0]), 0);
        chk("ovr_req_hold", int'(req[0]), 1);
        #2 Reset = 1'b0;
        #1;
        chk("arst_req", int'(req[0]), 0);
        chk("arst_px", int'(px[0]), 202);
        chk("arst_py", int'(py[0]), 253);
        ack_en[0] = 1'b1; key[0] = 8'h00;
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk);

        // FRAME_DIV=4: one pixel per four ticks.
        do_reset();
        key[1] = 8'h07;
        ticks(3);
        chk("div4_px3", int'(px[1]), 202);
        ticks(1);
        chk("div4_px4", int'(px[1]), 203);
        chk("div4_last", int'(ld[1]), int'(DIR_RIGHT));
        ticks(4);
        chk("div4_px8", int'(px[1]), 204);
        key[1] = 8'h00;

        // Tunnel wrap both ways.
        do_reset();
        key[2] = 8'h04; ack_en[2] = 1'b0;
        @(negedge Clk) tick = 1'b1;
        @(negedge Clk) tick = 1'b0;
        chk("wrap_req", int'(req[2]), 1);
        chk("wrap_wx", int'(wx[2]), 383);
        ack_en[2] = 1'b1;
        @(negedge Clk);
        chk("wrap_px", int'(px[2]), 383);
        chk("wrap_dir", int'(dr[2]), int'(DIR_LEFT));
        repeat (3) @(negedge Clk);
        key[2] = 8'h07;
        ticks(1);
        chk("wrap_back_px", int'(px[2]), 20);
        chk("wrap_back_dir", int'(dr[2]), int'(DIR_RIGHT));
        key[2] = 8'h00;

        // Right border: illegal candidate issues no probe.
        do_reset();
        key[3] = 8'h07;
        ticks(2);
        chk("edge_px", int'(px[3]), 383);
        p = probes[3];
        ticks(1);
        chk("edge_px_hold", int'(px[3]), 383);
        chk("edge_mv", int'(mv[3]), 0);
        chk("edge_no_probe", probes[3] - p, 0);
        chk("edge_dir", int'(dr[3]), int'(DIR_RIGHT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
